mult_sequencer: RTL and testbench

- Multi-cycle 32x32 -> 64-bit multiplier controller for the MIPS MULT/MULTU path.
- Sequences a single instance of the existing 32-bit adder (carry_select_adder_32bit) as a radix-2 shift-add engine.
- Produces HI/LO for the HI/LO register writeback and raises busy so the pipeline can stall.
- Uses one adder across 32 iterations instead of a combinational array multiplier.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mult_sequencer_if.sv | 22 ++
 rtl/carry_select_adder_32bit.sv | 26 ++
 rtl/mult_sequencer.sv | 107 ++++++++++
 tb/tb_mult_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: multiplier sequencer state encoding, iteration
// constants and the two's-complement magnitude helper.
package mips_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_MUL  = 2'd1,
        MS_NEG  = 2'd2,
        MS_DONE = 2'd3
    } ms_state_e;

    localparam int MULT_ITER  = 32;
    localparam int MULT_CNT_W = 5;

    // 0x80000000 maps to itself, which reads correctly as unsigned 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/result bundle between the pipeline and the multi-cycle multiplier.
interface mult_sequencer_if;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, is_signed, op_a, op_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/carry_select_adder_32bit.sv
// 32-bit carry-select adder built from eight 4-bit blocks, each block
// precomputing both carry-in outcomes and picking one off the carry chain.
module carry_select_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        c_out
);
    logic [8:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_blk
            logic [4:0] sum0;
            logic [4:0] sum1;
            assign sum0 = {1'b0, a[gi*4 +: 4]} + {1'b0, b[gi*4 +: 4]};
            assign sum1 = sum0 + 5'd1;
            assign sum[gi*4 +: 4] = carry[gi] ? sum1[3:0] : sum0[3:0];
            assign carry[gi+1]    = carry[gi] ? sum1[4]   : sum0[4];
        end
    endgenerate

    assign c_out = carry[8];
endmodule

// File: rtl/mult_sequencer.sv
// Radix-2 shift-add 32x32->64 multiplier for MULT/MULTU. Signed operands are
// multiplied as magnitudes and the product is negated in a final step.
module mult_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_sequencer_if.slave  bus
);
    ms_state_e              state_reg, state_next;
    logic [MULT_CNT_W-1:0]  count_reg;
    logic [WIDTH-1:0]       mcand_reg, mult_reg, acc_hi_reg;
    logic [WIDTH-1:0]       hi_reg, lo_reg;
    logic                   neg_reg;

    logic                   accept, last_iter, signed_op;
    logic [31:0]            add_b, add_sum;
    logic                   add_cout;
    logic [2*WIDTH-1:0]     mul_prod, neg_prod;

    assign accept    = (state_reg == MS_IDLE) && bus.start && !bus.flush;
    assign last_iter = (count_reg == MULT_CNT_W'(MULT_ITER - 1));
    assign signed_op = bus.is_signed & SIGNED_EN;

    assign add_b = mult_reg[0] ? mcand_reg : '0;

    carry_select_adder_32bit u_adder (
        .a     (acc_hi_reg),
        .b     (add_b),
        .cin   (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // {c_out, sum, mult} >> 1, keeping the adder carry as the new MSB.
    assign mul_prod = {add_cout, add_sum, mult_reg[WIDTH-1:1]};
    assign neg_prod = ~{acc_hi_reg, mult_reg} + (2*WIDTH)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= MS_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MS_IDLE: if (accept) state_next = MS_MUL;
            MS_MUL: begin
                if (bus.flush)     state_next = MS_IDLE;
                else if (last_iter) state_next = neg_reg ? MS_NEG : MS_DONE;
            end
            MS_NEG:  state_next = bus.flush ? MS_IDLE : MS_DONE;
            MS_DONE: state_next = MS_IDLE;
            default: state_next = MS_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_reg != MS_IDLE);
        bus.done = (state_reg == MS_DONE);
        bus.hi   = hi_reg;
        bus.lo   = lo_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            mcand_reg  <= '0;
            mult_reg   <= '0;
            acc_hi_reg <= '0;
            neg_reg    <= 1'b0;
        end else begin
            case (state_reg)
                MS_IDLE: if (accept) begin
                    // A zero operand gives a zero product, never a negated one.
                    neg_reg    <= signed_op & (bus.op_a[31] ^ bus.op_b[31])
                                  & (|bus.op_a) & (|bus.op_b);
                    mcand_reg  <= signed_op ? mag32(bus.op_a) : bus.op_a;
                    mult_reg   <= signed_op ? mag32(bus.op_b) : bus.op_b;
                    acc_hi_reg <= '0;
                    count_reg  <= '0;
                end
                MS_MUL: begin
                    {acc_hi_reg, mult_reg} <= mul_prod;
                    count_reg              <= count_reg + 1'b1;
                end
                MS_NEG:  {acc_hi_reg, mult_reg} <= neg_prod;
                default: ;
            endcase
        end
    end

    // Results are committed on the edge that enters DONE, from whichever
    // value the accumulator is being loaded with on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (state_next == MS_DONE && state_reg != MS_DONE) begin
            if (state_reg == MS_NEG) {hi_reg, lo_reg} <= neg_prod;
            else                     {hi_reg, lo_reg} <= mul_prod;
        end
    end
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed-vector and back-to-back regression bench for mult_sequencer.
module tb_mult_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_sequencer_if bus ();

    mult_sequencer #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Golden product from the language's own 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // 32 MUL cycles + DONE, plus one NEG cycle for a negative signed product.
    function automatic int ref_busy(input logic s, input logic [31:0] a, input logic [31:0] b);
        return (s && a != 0 && b != 0 && (a[31] ^ b[31])) ? 34 : 33;
    endfunction

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.is_signed = s;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts busy cycles up to and including the done cycle; -1 on timeout.
    task automatic wait_done(output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy) cyc++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic check_result(input string name, input logic s, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] ehi,
                                input logic [31:0] elo, input int ebusy, input int cyc);
        check({name, " busy_cycles"}, 64'(cyc), 64'(ebusy));
        check({name, " hi"}, {32'b0, bus.hi}, {32'b0, ehi});
        check({name, " lo"}, {32'b0, bus.lo}, {32'b0, elo});
        $display("op %s signed=%0d a=%08h b=%08h -> hi=%08h lo=%08h busy=%0d",
                 name, s, a, b, bus.hi, bus.lo, cyc);
    endtask

    task automatic run_vec(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi,
                           input logic [31:0] elo, input int ebusy);
        int cyc;
        launch(s, a, b);
        wait_done(cyc);
        check_result(name, s, a, b, ehi, elo, ebusy, cyc);
    endtask

    initial begin
        int          cyc;
        bit          done_seen;
        logic        cur_s, nxt_s;
        logic [31:0] cur_a, cur_b, nxt_a, nxt_b;
        logic [63:0] p;

        vecs[0] = '{"u7x6",      1'b0, 32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A, 33};
        vecs[1] = '{"uFFxFF",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[2] = '{"s-3x5",     1'b1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
        vecs[3] = '{"s80x80",    1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
        vecs[4] = '{"s-1x0",     1'b1, 32'hFFFF_FFFF, 32'd0,        32'h0000_0000, 32'h0000_0000, 33};
        vecs[5] = '{"s-7x-6",    1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_002A, 33};
        vecs[6] = '{"s7Fx-1",    1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 34};
        vecs[7] = '{"s80x1",     1'b1, 32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[8] = '{"u-3x5",     1'b0, 32'hFFFF_FFFD, 32'd5,        32'h0000_0004, 32'hFFFF_FFF1, 33};
        vecs[9] = '{"u80x2",     1'b0, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, 33};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {63'b0, bus.busy}, 64'd0);
        check("reset done", {63'b0, bus.done}, 64'd0);
        check("reset hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_vec(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].busy_cycles);

        // Prior result 0x1_00000002, then abort a new op by flush.
        run_vec("prior", 1'b0, 32'd2, 32'h8000_0001, 32'h1, 32'h2, 33);
        @(negedge clk);
        check("idle after done", {63'b0, bus.busy}, 64'd0);
        launch(1'b0, 32'd5, 32'd7);
        done_seen = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            done_seen |= bus.done;
            if (k == 5)  bus.start = 1'b1;
            if (k == 6)  bus.start = 1'b0;
            if (k == 10) bus.flush = 1'b1;
        end
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {63'b0, bus.busy}, 64'd0);
        check("flush no done", {63'b0, done_seen | bus.done}, 64'd0);
        check("flush hilo kept", {bus.hi, bus.lo}, 64'h0000_0001_0000_0002);
        $display("op flush-abort busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);

        // start with flush in IDLE must not be accepted.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        check("start+flush busy", {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start+flush idle", {63'b0, bus.busy}, 64'd0);
        $display("op start+flush busy=%0d", bus.busy);

        // Asynchronous reset partway through the iterations.
        launch(1'b0, 32'd123, 32'd456);
        repeat (17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", {63'b0, bus.busy}, 64'd0);
        check("async rst done", {63'b0, bus.done}, 64'd0);
        check("async rst hilo", {bus.hi, bus.lo}, 64'd0);
        $display("op async-reset busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("u2x3", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 33);

        // Back-to-back regression with start raised during DONE.
        cur_s = 1'($urandom_range(0, 1));
        cur_a = $urandom;
        cur_b = $urandom;
        launch(cur_s, cur_a, cur_b);
        for (int n = 0; n < 300; n++) begin
            wait_done(cyc);
            p = ref_mul(cur_s, cur_a, cur_b);
            check_result($sformatf("rnd%0d", n), cur_s, cur_a, cur_b,
                         p[63:32], p[31:0], ref_busy(cur_s, cur_a, cur_b), cyc);
            if (n < 299) begin
                nxt_s = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0:       nxt_a = 32'd0;
                    1:       nxt_a = 32'h8000_0000;
                    2:       nxt_a = 32'hFFFF_FFFF;
                    default: nxt_a = $urandom;
                endcase
                case ($urandom_range(0, 7))
                    0:       nxt_b = 32'd0;
                    1:       nxt_b = 32'h8000_0000;
                    default: nxt_b = $urandom;
                endcase
                bus.is_signed = nxt_s;
                bus.op_a      = nxt_a;
                bus.op_b      = nxt_b;
                bus.start     = 1'b1;
                @(posedge clk);
                #1;
                check("no accept in done", {63'b0, bus.busy}, 64'd0);
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                cur_s = nxt_s;
                cur_a = nxt_a;
                cur_b = nxt_b;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
